// File: rtl/pe_state_sequencer_pkg.sv
// Shared definitions for the PE state sequencer slice.
// Holds the compute-step vector widths, the loop-bound maxima, the derived
// field widths, the PE state encoding and the State_of_PE record layout that
// the activation RAM and weight buffer consume.
package pe_state_sequencer_pkg;

    localparam int unsigned I     = 4;   // activations per compute step
    localparam int unsigned F     = 4;   // weights per compute step
    localparam int unsigned MAX_A = 64;  // compressed activations per channel
    localparam int unsigned MAX_W = 64;  // compressed weights per channel per k-group
    localparam int unsigned MAX_C = 8;   // input channels
    localparam int unsigned MAX_K = 8;   // k-groups
    localparam int unsigned MAX_L = 8;   // conv layers

    // Index widths (hold 0 .. MAX-1)
    localparam int unsigned LW = $clog2(MAX_L);
    localparam int unsigned CW = $clog2(MAX_C);
    localparam int unsigned KW = $clog2(MAX_K);

    // Count/offset widths (hold 0 .. MAX)
    localparam int unsigned AW     = $clog2(MAX_A) + 1;
    localparam int unsigned WW     = $clog2(MAX_W) + 1;
    localparam int unsigned CFG_LW = LW + 1;
    localparam int unsigned CFG_CW = CW + 1;
    localparam int unsigned CFG_KW = KW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_PPU     = 2'd3
    } pe_state_e;

    typedef struct packed {
        pe_state_e       state;
        logic [LW-1:0]   layer;
        logic [CW-1:0]   c;
        logic [KW-1:0]   k;
        logic [AW-1:0]   a;
        logic [WW-1:0]   w;
        logic [AW-1:0]   remain_a;
        logic [WW-1:0]   remain_w;
        logic            flag_a;
        logic            flag_w;
    } State_of_PE;

endpackage

// File: rtl/pe_state_sequencer_if.sv
// Bus between the PE state sequencer and its neighbours (DRAM loader,
// multiplier array, PPU, activation RAM / weight buffer).
//   master : environment side - drives start, layer config, per-channel
//            counts and the load_done / mul_ready / ppu_done handshakes.
//   slave  : sequencer side - drives the state code, loop indices, block
//            offsets, remaining counts, flags, step_valid and net_done,
//            plus the packed State_of_PE record.
interface pe_state_sequencer_if;
    import pe_state_sequencer_pkg::*;

    logic              start;
    logic [CFG_LW-1:0] cfg_num_layers;
    logic [CFG_CW-1:0] cfg_num_c;
    logic [CFG_KW-1:0] cfg_num_k;
    logic [AW-1:0]     a_count;
    logic [WW-1:0]     w_count;
    logic              load_done;
    logic              mul_ready;
    logic              ppu_done;

    logic [1:0]        state;
    logic [LW-1:0]     Current_Conv_Layer;
    logic [CW-1:0]     Current_c;
    logic [KW-1:0]     Current_k;
    logic [AW-1:0]     Current_a;
    logic [WW-1:0]     Current_w;
    logic [AW-1:0]     remain_a;
    logic [WW-1:0]     remain_w;
    logic              Flag_remain_a;
    logic              Flag_remain_w;
    logic              step_valid;
    logic              net_done;
    State_of_PE        pe_state_rec;

    modport master (
        output start, cfg_num_layers, cfg_num_c, cfg_num_k, a_count, w_count,
               load_done, mul_ready, ppu_done,
        input  state, Current_Conv_Layer, Current_c, Current_k, Current_a,
               Current_w, remain_a, remain_w, Flag_remain_a, Flag_remain_w,
               step_valid, net_done, pe_state_rec
    );

    modport slave (
        input  start, cfg_num_layers, cfg_num_c, cfg_num_k, a_count, w_count,
               load_done, mul_ready, ppu_done,
        output state, Current_Conv_Layer, Current_c, Current_k, Current_a,
               Current_w, remain_a, remain_w, Flag_remain_a, Flag_remain_w,
               step_valid, net_done, pe_state_rec
    );

endinterface

// File: rtl/pe_state_sequencer_block.sv
// pe_block_counter: block offset walker for one operand stream.
// Steps an offset by STEP through 0 .. count-1 and reports the remaining
// element count and whether a full vector of STEP is still available.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the offset to 0
//   adv      : advance one block (wraps to 0 after the last block)
//   count    : number of elements in the stream
//   offset   : current block start offset
//   remain   : count - offset
//   flag     : remain >= STEP
//   last     : current block is the final one (offset + STEP >= count)
module pe_block_counter #(
    parameter int unsigned STEP = 4,
    parameter int unsigned W    = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] count,
    output logic [W-1:0] offset,
    output logic [W-1:0] remain,
    output logic         flag,
    output logic         last
);

    // One extra bit so offset + STEP cannot wrap near the top of the range
    logic [W:0] next_off;

    always_comb begin
        next_off = {1'b0, offset} + (W+1)'(STEP);
        last     = next_off >= {1'b0, count};
        remain   = count - offset;
        flag     = remain >= W'(STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
        end else if (clr) begin
            offset <= '0;
        end else if (adv) begin
            offset <= last ? '0 : next_off[W-1:0];
        end
    end

endmodule

// File: rtl/pe_state_sequencer.sv
// pe_state_sequencer: per-PE scheduler for the SCNN Cartesian-product
// dataflow. Walks layer -> k-group -> input channel -> weight block ->
// activation block and publishes the PE state record.
//   clk  : clock
//   rst  : asynchronous active-high reset (aborts to IDLE, no net_done)
//   bus  : pe_state_sequencer_if.slave - config/handshake inputs and the
//          state code, indices, offsets, remain counts, flags, step_valid,
//          net_done and packed State_of_PE outputs
module pe_state_sequencer
    import pe_state_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pe_state_sequencer_if.slave   bus
);

    pe_state_e     state_q, state_n;
    logic [LW-1:0] layer_q, layer_n;
    logic [CW-1:0] c_q, c_n;
    logic [KW-1:0] k_q, k_n;
    logic          net_done_q, net_done_n;

    logic [AW-1:0] off_a, rem_a;
    logic [WW-1:0] off_w, rem_w;
    logic          flag_a, flag_w, last_a, last_w;

    logic in_compute, empty_ch, step_valid, retire, chan_done;
    logic last_c, last_k, last_layer, clr_blk;

    always_comb begin
        in_compute = (state_q == ST_COMPUTE);
        empty_ch   = (bus.a_count == '0) || (bus.w_count == '0);
        step_valid = in_compute && !empty_ch;
        retire     = step_valid && bus.mul_ready;
        // An empty channel is consumed in one cycle without retiring a step
        chan_done  = in_compute && (empty_ch || (retire && last_a && last_w));
        last_c     = ({1'b0, c_q} + CFG_CW'(1)) == bus.cfg_num_c;
        last_k     = ({1'b0, k_q} + CFG_KW'(1)) == bus.cfg_num_k;
        last_layer = ({1'b0, layer_q} + CFG_LW'(1)) == bus.cfg_num_layers;
        clr_blk    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    end

    // Activation blocks are innermost; the weight block advances only when
    // the activation walker wraps.
    pe_block_counter #(.STEP(I), .W(AW)) u_act_blk (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_blk),
        .adv    (retire),
        .count  (bus.a_count),
        .offset (off_a),
        .remain (rem_a),
        .flag   (flag_a),
        .last   (last_a)
    );

    pe_block_counter #(.STEP(F), .W(WW)) u_wgt_blk (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_blk),
        .adv    (retire && last_a),
        .count  (bus.w_count),
        .offset (off_w),
        .remain (rem_w),
        .flag   (flag_w),
        .last   (last_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            layer_q    <= '0;
            c_q        <= '0;
            k_q        <= '0;
            net_done_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            layer_q    <= layer_n;
            c_q        <= c_n;
            k_q        <= k_n;
            net_done_q <= net_done_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        layer_n    = layer_q;
        c_n        = c_q;
        k_n        = k_q;
        net_done_n = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_num_layers != '0) begin
                        state_n = ST_LOAD;
                        layer_n = '0;
                        c_n     = '0;
                        k_n     = '0;
                    end else begin
                        net_done_n = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                c_n = '0;
                k_n = '0;
                if (bus.load_done) begin
                    state_n = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (chan_done) begin
                    if (last_c) begin
                        state_n = ST_PPU;
                    end else begin
                        c_n = c_q + CW'(1);
                    end
                end
            end
            ST_PPU: begin
                if (bus.ppu_done) begin
                    c_n = '0;
                    if (!last_k) begin
                        k_n     = k_q + KW'(1);
                        state_n = ST_COMPUTE;
                    end else if (!last_layer) begin
                        layer_n = layer_q + LW'(1);
                        k_n     = '0;
                        state_n = ST_LOAD;
                    end else begin
                        state_n    = ST_IDLE;
                        net_done_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.state              = state_q;
    assign bus.Current_Conv_Layer = layer_q;
    assign bus.Current_c          = c_q;
    assign bus.Current_k          = k_q;
    assign bus.Current_a          = off_a;
    assign bus.Current_w          = off_w;
    assign bus.remain_a           = rem_a;
    assign bus.remain_w           = rem_w;
    assign bus.Flag_remain_a      = flag_a;
    assign bus.Flag_remain_w      = flag_w;
    assign bus.step_valid         = step_valid;
    assign bus.net_done           = net_done_q;
    assign bus.pe_state_rec       = '{
        state:    state_q,
        layer:    layer_q,
        c:        c_q,
        k:        k_q,
        a:        off_a,
        w:        off_w,
        remain_a: rem_a,
        remain_w: rem_w,
        flag_a:   flag_a,
        flag_w:   flag_w
    };

endmodule

// File: tb/tb_pe_state_sequencer.sv
// Self-checking bench for pe_state_sequencer. A loop-nest reference model
// expands each network configuration into the ordered list of phases
// (LOAD, compute steps, empty-channel skips, PPU) and the bench walks that
// list cycle by cycle under randomized handshakes.
module tb_pe_state_sequencer;
    import pe_state_sequencer_pkg::*;

    localparam int OP_LOAD = 1;
    localparam int OP_STEP = 2;
    localparam int OP_SKIP = 3;
    localparam int OP_PPU  = 4;
    localparam int BUDGET  = 20000;

    typedef struct {
        int kind;
        int layer;
        int k;
        int c;
        int a;
        int w;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_state_sequencer_if bus();

    pe_state_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int  acnt [8];
    int  wcnt [8][8];
    op_t ops [$];

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic void build_model(input int nl, input int nc, input int nk);
        op_t e;
        ops.delete();
        for (int l = 0; l < nl; l++) begin
            e = '{OP_LOAD, l, 0, 0, 0, 0};
            ops.push_back(e);
            for (int k = 0; k < nk; k++) begin
                for (int c = 0; c < nc; c++) begin
                    if (acnt[c] == 0 || wcnt[k][c] == 0) begin
                        e = '{OP_SKIP, l, k, c, 0, 0};
                        ops.push_back(e);
                    end else begin
                        for (int w = 0; w < wcnt[k][c]; w += F) begin
                            for (int a = 0; a < acnt[c]; a += I) begin
                                e = '{OP_STEP, l, k, c, a, w};
                                ops.push_back(e);
                            end
                        end
                    end
                end
                e = '{OP_PPU, l, k, nc - 1, 0, 0};
                ops.push_back(e);
            end
        end
    endfunction

    function automatic int exp_steps(input int nl, input int nc, input int nk);
        int s = 0;
        for (int k = 0; k < nk; k++)
            for (int c = 0; c < nc; c++)
                s += ceil_div(acnt[c], I) * ceil_div(wcnt[k][c], F);
        return s * nl;
    endfunction

    task automatic idle_inputs();
        bus.start          = 1'b0;
        bus.load_done      = 1'b0;
        bus.mul_ready      = 1'b0;
        bus.ppu_done       = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mr_mode: 0 = mul_ready always high, 1 = random, 2 = repeating 1,0,0,1
    task automatic run_network(input int nl, input int nc, input int nk, input int mr_mode,
                               output int steps_seen, output int done_pulses);
        op_t e;
        int  p;
        int  cyc;
        int  exp_state;
        int  ra;
        int  rw;
        bit  pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        steps_seen  = 0;
        done_pulses = 0;
        build_model(nl, nc, nk);
        apply_reset();

        @(negedge clk);
        bus.cfg_num_layers = CFG_LW'(nl);
        bus.cfg_num_c      = CFG_CW'(nc);
        bus.cfg_num_k      = CFG_KW'(nk);
        bus.start          = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'd0) begin
            errors++;
            $display("FAIL idle_before_start got=%0d exp=0", bus.state);
        end

        p   = 0;
        cyc = 0;
        while (p < ops.size() && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            e = ops[p];
            bus.a_count   = AW'(acnt[e.c]);
            bus.w_count   = WW'(wcnt[e.k][e.c]);
            bus.start     = 1'($urandom_range(0, 1));
            bus.load_done = ($urandom_range(0, 2) == 0);
            bus.ppu_done  = ($urandom_range(0, 2) == 0);
            case (mr_mode)
                0:       bus.mul_ready = 1'b1;
                1:       bus.mul_ready = 1'($urandom_range(0, 1));
                default: bus.mul_ready = pat[cyc % 4];
            endcase
            #1;
            exp_state = (e.kind == OP_LOAD) ? 1 : (e.kind == OP_PPU) ? 3 : 2;
            checks++;
            if (int'(bus.state) !== exp_state) begin
                errors++;
                $display("FAIL state cyc=%0d op=%0d got=%0d exp=%0d", cyc, p, bus.state, exp_state);
            end
            checks++;
            if (int'(bus.pe_state_rec.state) !== exp_state) begin
                errors++;
                $display("FAIL rec_state cyc=%0d got=%0d exp=%0d", cyc, bus.pe_state_rec.state, exp_state);
            end
            checks++;
            if (int'(bus.Current_Conv_Layer) !== e.layer) begin
                errors++;
                $display("FAIL layer cyc=%0d got=%0d exp=%0d", cyc, bus.Current_Conv_Layer, e.layer);
            end
            checks++;
            if (int'(bus.Current_k) !== e.k) begin
                errors++;
                $display("FAIL k cyc=%0d got=%0d exp=%0d", cyc, bus.Current_k, e.k);
            end
            checks++;
            if (int'(bus.Current_c) !== e.c) begin
                errors++;
                $display("FAIL c cyc=%0d got=%0d exp=%0d", cyc, bus.Current_c, e.c);
            end
            checks++;
            if (int'(bus.Current_a) !== e.a || int'(bus.Current_w) !== e.w) begin
                errors++;
                $display("FAIL offsets cyc=%0d got a=%0d w=%0d exp a=%0d w=%0d",
                         cyc, bus.Current_a, bus.Current_w, e.a, e.w);
            end
            checks++;
            if (bus.step_valid !== (e.kind == OP_STEP)) begin
                errors++;
                $display("FAIL step_valid cyc=%0d got=%0d exp=%0d", cyc, bus.step_valid, e.kind == OP_STEP);
            end
            checks++;
            if (bus.net_done !== 1'b0) begin
                errors++;
                $display("FAIL net_done_early cyc=%0d got=%0d exp=0", cyc, bus.net_done);
            end
            if (e.kind == OP_STEP) begin
                ra = acnt[e.c] - e.a;
                rw = wcnt[e.k][e.c] - e.w;
                checks++;
                if (int'(bus.remain_a) !== ra || bus.Flag_remain_a !== (ra >= I)) begin
                    errors++;
                    $display("FAIL remain_a cyc=%0d got=%0d/%0d exp=%0d/%0d",
                             cyc, bus.remain_a, bus.Flag_remain_a, ra, ra >= I);
                end
                checks++;
                if (int'(bus.remain_w) !== rw || bus.Flag_remain_w !== (rw >= F)) begin
                    errors++;
                    $display("FAIL remain_w cyc=%0d got=%0d/%0d exp=%0d/%0d",
                             cyc, bus.remain_w, bus.Flag_remain_w, rw, rw >= F);
                end
            end
            if (bus.step_valid === 1'b1 && bus.mul_ready === 1'b1)
                steps_seen++;
            case (e.kind)
                OP_LOAD: if (bus.load_done) p++;
                OP_STEP: if (bus.mul_ready) p++;
                OP_SKIP: p++;
                default: if (bus.ppu_done)  p++;
            endcase
        end
        checks++;
        if (cyc >= BUDGET) begin
            errors++;
            $display("FAIL timeout got=%0d ops exp=%0d ops", p, ops.size());
        end

        @(negedge clk);
        idle_inputs();
        #1;
        if (bus.net_done === 1'b1) done_pulses++;
        checks++;
        if (bus.state !== 2'd0 || bus.net_done !== 1'b1) begin
            errors++;
            $display("FAIL finish got state=%0d done=%0d exp state=0 done=1", bus.state, bus.net_done);
        end
        @(negedge clk);
        #1;
        if (bus.net_done === 1'b1) done_pulses++;
        checks++;
        if (bus.net_done !== 1'b0 || bus.state !== 2'd0) begin
            errors++;
            $display("FAIL done_pulse_width got state=%0d done=%0d exp state=0 done=0", bus.state, bus.net_done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.Current_Conv_Layer !== '0 || bus.Current_c !== '0 ||
            bus.Current_k !== '0 || bus.Current_a !== '0 || bus.Current_w !== '0 ||
            bus.step_valid !== 1'b0 || bus.net_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got st=%0d l=%0d c=%0d k=%0d a=%0d w=%0d sv=%0d nd=%0d exp all 0",
                     bus.state, bus.Current_Conv_Layer, bus.Current_c, bus.Current_k,
                     bus.Current_a, bus.Current_w, bus.step_valid, bus.net_done);
        end
    endtask

    task automatic test_directed(input string name, input int nl, input int nc, input int nk,
                                 input int mr_mode);
        int steps;
        int dones;
        int want;
        want = exp_steps(nl, nc, nk);
        run_network(nl, nc, nk, mr_mode, steps, dones);
        checks++;
        if (steps !== want) begin
            errors++;
            $display("FAIL %s_steps got=%0d exp=%0d", name, steps, want);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses got=%0d exp=1", name, dones);
        end
    endtask

    task automatic test_exact_multiple();
        acnt[0] = 8; wcnt[0][0] = 4;
        test_directed("exact", 1, 1, 1, 0);
    endtask

    task automatic test_partial();
        acnt[0] = 6; wcnt[0][0] = 6;
        test_directed("partial", 1, 1, 1, 0);
    endtask

    task automatic test_empty_channel();
        acnt[0] = 5; acnt[1] = 0; acnt[2] = 9;
        for (int c = 0; c < 3; c++) wcnt[0][c] = 7;
        test_directed("empty_ch", 1, 3, 1, 1);
    endtask

    task automatic test_stall();
        acnt[0] = 16; wcnt[0][0] = 8;
        test_directed("stall", 1, 1, 1, 2);
    endtask

    task automatic test_multi_layer();
        acnt[0] = 4; acnt[1] = 12;
        wcnt[0][0] = 8; wcnt[0][1] = 3; wcnt[1][0] = 1; wcnt[1][1] = 0;
        test_directed("multi_layer", 2, 2, 2, 1);
    endtask

    task automatic test_max_counts();
        acnt[0] = 64; acnt[1] = 63;
        wcnt[0][0] = 64; wcnt[0][1] = 61;
        test_directed("max_counts", 1, 2, 1, 0);
    endtask

    task automatic test_random();
        int nl;
        int nc;
        int nk;
        for (int r = 0; r < 5; r++) begin
            nl = $urandom_range(1, 3);
            nc = $urandom_range(1, 8);
            nk = $urandom_range(1, 3);
            for (int c = 0; c < 8; c++) begin
                acnt[c] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
                for (int k = 0; k < 8; k++)
                    wcnt[k][c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            end
            test_directed("random", nl, nc, nk, 1);
        end
    endtask

    task automatic test_zero_layers();
        apply_reset();
        @(negedge clk);
        bus.cfg_num_layers = '0;
        bus.start          = 1'b1;
        #1;
        checks++;
        if (bus.net_done !== 1'b0 || bus.state !== 2'd0) begin
            errors++;
            $display("FAIL zero_layers_pre got state=%0d done=%0d exp 0/0", bus.state, bus.net_done);
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.net_done !== 1'b1 || bus.state !== 2'd0) begin
            errors++;
            $display("FAIL zero_layers_pulse got state=%0d done=%0d exp 0/1", bus.state, bus.net_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.net_done !== 1'b0 || bus.state !== 2'd0) begin
            errors++;
            $display("FAIL zero_layers_post got state=%0d done=%0d exp 0/0", bus.state, bus.net_done);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        bus.cfg_num_layers = CFG_LW'(1);
        bus.cfg_num_c      = CFG_CW'(1);
        bus.cfg_num_k      = CFG_KW'(1);
        bus.a_count        = AW'(16);
        bus.w_count        = WW'(16);
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.load_done = 1'b1;
        @(negedge clk);
        bus.load_done = 1'b0;
        bus.mul_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 2'd2 || int'(bus.Current_a) !== 3 * I) begin
            errors++;
            $display("FAIL pre_abort got state=%0d a=%0d exp state=2 a=%0d", bus.state, bus.Current_a, 3 * I);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.Current_a !== '0 || bus.Current_w !== '0 ||
            bus.Current_c !== '0 || bus.Current_k !== '0 || bus.Current_Conv_Layer !== '0 ||
            bus.step_valid !== 1'b0 || bus.net_done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort got st=%0d a=%0d w=%0d c=%0d k=%0d l=%0d sv=%0d nd=%0d exp all 0",
                     bus.state, bus.Current_a, bus.Current_w, bus.Current_c, bus.Current_k,
                     bus.Current_Conv_Layer, bus.step_valid, bus.net_done);
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            #1;
            checks++;
            if (bus.net_done !== 1'b0 || bus.state !== 2'd0) begin
                errors++;
                $display("FAIL abort_no_done got state=%0d done=%0d exp 0/0", bus.state, bus.net_done);
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.cfg_num_layers = '0;
        bus.cfg_num_c      = CFG_CW'(1);
        bus.cfg_num_k      = CFG_KW'(1);
        bus.a_count        = '0;
        bus.w_count        = '0;
        for (int c = 0; c < 8; c++) begin
            acnt[c] = 0;
            for (int k = 0; k < 8; k++) wcnt[k][c] = 0;
        end
        rst = 1'b1;
        #12;
        test_reset();
        rst = 1'b0;
        test_exact_multiple();
        test_partial();
        test_empty_channel();
        test_stall();
        test_multi_layer();
        test_max_counts();
        test_zero_layers();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_state_sequencer.md
Name: pe_state_sequencer

Overview:
- Per-PE scheduler that generates the PE state record consumed by the input/output activation RAM and weight buffer.
- Walks the layer, output-channel-group (k), input-channel (c), weight-block and activation-block loops of the SCNN Cartesian-product dataflow.
- Emits the state code plus current offsets and remaining counts.
- Handshakes with the DRAM loader, the multiplier array and the PPU.

Parameters:
- I, 4, activation vector width per compute step
- F, 4, weight vector width per compute step
- MAX_A, 64, max compressed activations per channel
- MAX_W, 64, max compressed weights per channel per k-group
- MAX_C, 8, max input channels
- MAX_K, 8, max k-groups
- MAX_L, 8, max conv layers

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin network; sampled only in IDLE
- cfg_num_layers  in  $clog2(MAX_L)+1  layers to run (0 = none)
- cfg_num_c  in  $clog2(MAX_C)+1  input channels in current layer (>=1)
- cfg_num_k  in  $clog2(MAX_K)+1  k-groups in current layer (>=1)
- a_count  in  $clog2(MAX_A)+1  nonzero activations of channel Current_c
- w_count  in  $clog2(MAX_W)+1  nonzero weights of (Current_k, Current_c)
- load_done  in  1  DRAM loader finished layer input fill
- mul_ready  in  1  multiplier array accepts a step this cycle
- ppu_done  in  1  PPU drained outputs and the next weights are in place
- state  out  2  0 IDLE, 1 LOAD, 2 COMPUTE, 3 PPU
- Current_Conv_Layer  out  $clog2(MAX_L)  layer index; bit0 selects the ping-pong RAM
- Current_c  out  $clog2(MAX_C)  channel index
- Current_k  out  $clog2(MAX_K)  k-group index
- Current_a  out  $clog2(MAX_A)+1  activation block start offset
- Current_w  out  $clog2(MAX_W)+1  weight block start offset
- remain_a  out  $clog2(MAX_A)+1  a_count - Current_a
- remain_w  out  $clog2(MAX_W)+1  w_count - Current_w
- Flag_remain_a  out  1  remain_a >= I
- Flag_remain_w  out  1  remain_w >= F
- step_valid  out  1  COMPUTE step presented this cycle
- net_done  out  1  one-cycle pulse when last layer completes

Behaviour:
- Reset (async):
  - state = IDLE; all indices/offsets 0; step_valid 0; net_done 0.
  - remain_* and Flag_* are combinational from registers and inputs.
- All state and counter updates happen on posedge clk.
- IDLE:
  - start=1 and cfg_num_layers>0 -> LOAD, layer = 0.
  - start=1 and cfg_num_layers=0 -> net_done pulse next cycle; stay IDLE.
  - start outside IDLE is ignored.
- LOAD:
  - Hold; c = k = a = w = 0.
  - load_done=1 -> COMPUTE next cycle.
- COMPUTE:
  - step_valid = 1 unless the current channel is empty.
  - A step retires when step_valid && mul_ready. mul_ready low holds all counters (stall).
  - Loop order, innermost first:
    - a += I while a + I < a_count; else a = 0 and w += F.
    - When w + F >= w_count: w = 0 and c++.
    - When c = cfg_num_c - 1: -> PPU.
  - Empty channel (a_count = 0 or w_count = 0): step_valid = 0; c advances in one cycle with no step retired.
  - Exact multiples: a_count = 8, I = 4 -> offsets 0, 4 only; Flag_remain_a = 1 on both.
  - Partial: a_count = 6 -> offsets 0 (remain 6, flag 1), 4 (remain 2, flag 0).
- PPU:
  - Hold all indices.
  - ppu_done=1 and k < cfg_num_k - 1 -> k++, c = 0 -> COMPUTE (weights refilled during PPU).
  - ppu_done=1 and last k:
    - layer < cfg_num_layers - 1 -> layer++, k = 0 -> LOAD.
    - Last layer -> IDLE and net_done pulse.
- cfg_* and a_count/w_count are sampled combinationally each cycle and must be stable while in use; changing them mid-layer is unsupported.
- Arithmetic: comparisons use widened widths, so no wrap-around. Offsets never exceed MAX_A-1 / MAX_W-1.
- rst during any state aborts immediately to IDLE with no net_done.
- Simultaneous events:
  - load_done in non-LOAD states is ignored.
  - ppu_done in non-PPU states is ignored.
  - mul_ready in non-COMPUTE states is ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/LOAD/COMPUTE/PPU = 0..3)
  - I, F, MAX_* defines
  - the State_of_PE struct packing state, indices, remain_* and Flag_* fields
- One natural sub-module, pe_block_counter: offset/remain/flag counter with step size and count inputs. Instantiated twice (activation with step I, weight with step F).

Test Plan:
- a_count=8, w_count=4, cfg_num_c=1, cfg_num_k=1, 1 layer, mul_ready=1 -> 2 steps, Current_a 0 then 4, Flag_remain_a=1 both; PPU entered at step 3; ppu_done -> IDLE + net_done.
- a_count=6, w_count=6 -> 4 steps, (a,w) = (0,0), (4,0), (0,4), (4,4); remain_a 6/2 with flag 1/0; remain_w 6/2 with flag 1/0.
- cfg_num_c=3, channel 1 has a_count=0 -> channel 1 skipped in one cycle with step_valid=0; total steps = channel 0 + channel 2 steps.
- mul_ready toggled 1,0,0,1 during COMPUTE -> offsets advance only on mul_ready=1 cycles; state stays 2.
- cfg_num_layers=2, cfg_num_k=2 -> sequence LOAD, COMPUTE, PPU, COMPUTE, PPU, LOAD; Current_Conv_Layer goes 0 -> 1 with bit0 flip; one net_done pulse at end.
- rst asserted mid-COMPUTE, async -> state=0 and all indices 0 before the next clock edge; no net_done.
